storage_stim_player: RTL and testbench

- Synthesizable stimulus sequencer and response checker for single-bit storage-element DUTs (latch, posedge FF, negedge FF).
- A loader writes a bit pattern into internal memory. On start, the block plays one bit per clock on d_out and samples the DUT response on q_in.
- Each response is compared against the played bit delayed by LAT cycles. Mismatches are counted and a pass/fail verdict is reported.
- Sits beside the storage-element DUT on the lab board or in the bench harness, replacing hand-written stimulus.

---
 rtl/storage_stim_player_if.sv | 33 +++
 rtl/storage_stim_player.sv | 100 ++++++++++
 tb/tb_storage_stim_player.sv | 136 +++++++++++++
 3 files changed

// File: rtl/storage_stim_player_if.sv
// storage_stim_player_if: loader, playback and result signals between the stimulus player and its controller/DUT model.
// Ports (signals): wr_en/wr_addr/wr_data pattern load, len/start run control,
//   d_out stimulus to DUT, q_in DUT response, busy/done/err_cnt/pass run status.
// Macro STIM_FIRST_ERR_EN adds first_err_vld/first_err_idx.
interface storage_stim_player_if #(
  parameter int AW = 4,
  parameter int CW = 8
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic [AW:0]   len;
  logic          start;
  logic          d_out;
  logic          q_in;
  logic          busy;
  logic          done;
  logic [CW-1:0] err_cnt;
  logic          pass;
`ifdef STIM_FIRST_ERR_EN
  logic          first_err_vld;
  logic [AW-1:0] first_err_idx;
  modport master (output wr_en, wr_addr, wr_data, len, start, q_in,
                  input d_out, busy, done, err_cnt, pass, first_err_vld, first_err_idx);
  modport slave  (input wr_en, wr_addr, wr_data, len, start, q_in,
                  output d_out, busy, done, err_cnt, pass, first_err_vld, first_err_idx);
`else
  modport master (output wr_en, wr_addr, wr_data, len, start, q_in,
                  input d_out, busy, done, err_cnt, pass);
  modport slave  (input wr_en, wr_addr, wr_data, len, start, q_in,
                  output d_out, busy, done, err_cnt, pass);
`endif
endinterface

// File: rtl/storage_stim_player.sv
// storage_stim_player: plays a stored bit pattern into a storage-element DUT and checks its delayed response.
// Ports: clk, reset (sync, active-high), bus (storage_stim_player_if.slave) carrying
//   pattern load, len/start, d_out/q_in and busy/done/err_cnt/pass.
// Macro STIM_FIRST_ERR_EN adds first-mismatch capture (first_err_vld/first_err_idx).
module storage_stim_player #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int LAT   = 1,
  parameter int CW    = 8
) (
  input logic                  clk,
  input logic                  reset,
  storage_stim_player_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, DRAIN, DONE} state_t;
  state_t         r_state, w_next;
  logic [DEPTH-1:0] r_mem;
  logic [AW:0]    r_len, r_idx, w_len;
  logic [LAT-1:0] r_dv, r_dd;
  logic           r_d, r_pass, w_cmp, w_mis;
  logic [CW-1:0]  r_err, w_err;
  assign w_len = (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;
  // oldest delay-line slot holds the bit played LAT cycles ago
  assign w_cmp = r_dv[LAT-1];
  assign w_mis = w_cmp && (bus.q_in != r_dd[LAT-1]);
  assign w_err = (w_mis && !(&r_err)) ? r_err + CW'(1) : r_err;
  assign bus.d_out   = r_d;
  assign bus.busy    = (r_state == PLAY) || (r_state == DRAIN);
  assign bus.done    = (r_state == DONE);
  assign bus.err_cnt = r_err;
  assign bus.pass    = r_pass;
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !bus.start ? IDLE : (bus.len == '0) ? DONE : PLAY;
      PLAY:    w_next = (r_idx == r_len) ? DRAIN : PLAY;
      DRAIN:   w_next = (r_idx == (AW+1)'(LAT-1)) ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset && r_state == IDLE && bus.wr_en && !bus.start)
      r_mem[bus.wr_addr] <= bus.wr_data;
  // r_idx is the next pattern address in PLAY and the drain cycle count in DRAIN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_d    <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= '0;
      r_len  <= '0;
      r_idx  <= '0;
      r_dv   <= '0;
      r_dd   <= '0;
    end else begin
      r_dv  <= LAT'({r_dv, r_state == PLAY});
      r_dd  <= LAT'({r_dd, r_d});
      r_err <= w_err;
      case (r_state)
        IDLE: if (bus.start) begin
          r_len  <= w_len;
          r_d    <= (w_len != '0) && r_mem[0];
          r_idx  <= (AW+1)'(1);
          r_err  <= '0;
          r_pass <= (w_len == '0);
        end
        PLAY: begin
          r_d   <= (r_idx == r_len) ? 1'b0 : r_mem[r_idx[AW-1:0]];
          r_idx <= (r_idx == r_len) ? '0 : r_idx + (AW+1)'(1);
        end
        DRAIN: begin
          r_idx <= r_idx + (AW+1)'(1);
          if (w_next == DONE) r_pass <= (w_err == '0);
        end
        default: ;
      endcase
    end
  end
`ifdef STIM_FIRST_ERR_EN
  logic          r_fev;
  logic [AW-1:0] r_fei, r_ck;
  // r_ck counts completed compares, which equals the index of the bit being compared
  always_ff @(posedge clk) begin
    if (reset || (r_state == IDLE && bus.start)) begin
      r_fev <= 1'b0;
      r_fei <= '0;
      r_ck  <= '0;
    end else if (w_cmp) begin
      r_ck <= r_ck + AW'(1);
      if (w_mis && !r_fev) begin
        r_fev <= 1'b1;
        r_fei <= r_ck;
      end
    end
  end
  assign bus.first_err_vld = r_fev;
  assign bus.first_err_idx = r_fei;
`endif
endmodule

// File: tb/tb_storage_stim_player.sv
// tb_storage_stim_player: table-driven check of storage_stim_player against modelled FF-style DUT responses.
module tb_storage_stim_player;
  typedef struct {
    int          mode;
    logic [4:0]  len;
    logic [15:0] pat;
    int          exp_busy;
    int          exp_err;
    logic        exp_pass;
    int          exp_sat;
    int          exp_fidx;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int   mode;
  int   cyc;
  logic q_ff;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tv[6];
  storage_stim_player_if #(.AW(4), .CW(8)) bus ();
  storage_stim_player_if #(.AW(4), .CW(4)) bus2 ();
  storage_stim_player #(.DEPTH(16), .AW(4), .LAT(1), .CW(8)) u_dut (.clk(clk), .reset(reset), .bus(bus));
  storage_stim_player #(.DEPTH(16), .AW(4), .LAT(1), .CW(4)) u_sat (.clk(clk), .reset(reset), .bus(bus2));
  always #5 clk = ~clk;
  // mode 0: ideal FF, 1: inverted FF, 2: zero-latency wire, 3: ideal FF with bit 5 corrupted
  always @(posedge clk) begin
    cyc  <= bus.start ? 0 : cyc + 1;
    q_ff <= bus.d_out ^ (mode == 3 && cyc == 5);
  end
  assign bus.q_in     = (mode == 2) ? bus.d_out : (mode == 1) ? ~q_ff : q_ff;
  assign bus2.wr_en   = bus.wr_en;
  assign bus2.wr_addr = bus.wr_addr;
  assign bus2.wr_data = bus.wr_data;
  assign bus2.len     = bus.len;
  assign bus2.start   = bus.start;
  assign bus2.q_in    = bus2.d_out;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, " d_out"}, 32'(bus.d_out), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
    chk({tag, " done"}, 32'(bus.done), 0);
    chk({tag, " err_cnt"}, 32'(bus.err_cnt), 0);
    chk({tag, " pass"}, 32'(bus.pass), 0);
  endtask
  task automatic run_case(input int id, input vec_t v, input bit do_wr, input bit extra_start);
    int  lc, busy_n, done_n;
    bit  seen;
    if (do_wr) begin
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = v.pat[i];
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
    end
    mode = v.mode; bus.len = v.len; bus.start = 1'b1;
    lc = (v.len > 16) ? 16 : int'(v.len);
    busy_n = 0; done_n = 0; seen = 0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      bus.start = extra_start && k == 3;
      if (bus.busy) busy_n++;
      if (k < lc) chk($sformatf("run%0d d_out[%0d]", id, k), 32'(bus.d_out), 32'(v.pat[k]));
      else chk($sformatf("run%0d d_out idle c%0d", id, k), 32'(bus.d_out), 0);
      if (bus.done) begin
        done_n++; seen = 1;
        chk($sformatf("run%0d err_cnt", id), 32'(bus.err_cnt), 32'(v.exp_err));
        chk($sformatf("run%0d pass", id), 32'(bus.pass), 32'(v.exp_pass));
        if (v.mode == 2) chk($sformatf("run%0d sat err_cnt", id), 32'(bus2.err_cnt), 32'(v.exp_sat));
`ifdef STIM_FIRST_ERR_EN
        chk($sformatf("run%0d first_err_vld", id), 32'(bus.first_err_vld), 32'(v.exp_fidx >= 0));
        if (v.exp_fidx >= 0) chk($sformatf("run%0d first_err_idx", id), 32'(bus.first_err_idx), 32'(v.exp_fidx));
`endif
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk($sformatf("run%0d done seen", id), 32'(seen), 1);
    chk($sformatf("run%0d busy cycles", id), 32'(busy_n), 32'(v.exp_busy));
    for (int k = 0; k < 3; k++) begin
      if (bus.done || bus.busy) done_n++;
      @(negedge clk);
    end
    chk($sformatf("run%0d done pulses", id), 32'(done_n), 1);
    chk($sformatf("run%0d err_cnt hold", id), 32'(bus.err_cnt), 32'(v.exp_err));
  endtask
  initial begin
    tv[0] = '{0, 5'd8,  16'h00B2, 9,  0,  1'b1, 0,  -1};
    tv[1] = '{1, 5'd8,  16'h00B2, 9,  8,  1'b0, 0,  0};
    tv[2] = '{2, 5'd16, 16'hAAAA, 17, 16, 1'b0, 15, 0};
    tv[3] = '{0, 5'd0,  16'hAAAA, 0,  0,  1'b1, 0,  -1};
    tv[4] = '{3, 5'd8,  16'h00B2, 9,  1,  1'b0, 0,  5};
    tv[5] = '{0, 5'd20, 16'hAAAA, 17, 0,  1'b1, 0,  -1};
    mode = 0; reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 1'b0; bus.len = '0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) run_case(i, tv[i], 1'b1, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("idle reset");
    reset = 1'b0;
    @(negedge clk);
    run_case(6, tv[0], 1'b1, 1'b1);
    mode = 1; bus.len = 5'd8; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun busy before reset", 32'(bus.busy), 1);
    chk("midrun err before reset", 32'(bus.err_cnt), 2);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("midrun reset");
    reset = 1'b0;
    begin
      int dn = 0;
      for (int k = 0; k < 12; k++) begin
        if (bus.done || bus.busy) dn++;
        @(negedge clk);
      end
      chk("midrun no done", 32'(dn), 0);
    end
    run_case(7, tv[0], 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
